ram512_arbiter: RTL and testbench
=================================

RAM512_ARBITER -- requirements
Module: ram512_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9: word-address width of the shared RAM (512 words).
REQ-002 Parameter DATA_W, default 16: data width of the shared RAM.
REQ-003 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 a_req  input  1  requester A transaction request (level).
REQ-007 a_we  input  1  requester A: 1 = write, 0 = read.
REQ-008 a_addr  input  ADDR_W  requester A word address.
REQ-009 a_wdata  input  DATA_W  requester A write data.
REQ-010 a_ack  output  1  one-cycle completion pulse to A.
REQ-011 a_rdata  output  DATA_W  read data to A, valid while a_ack=1 and held until next A read.
REQ-012 b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: identical set for requester B.
REQ-013 ram_address  output  ADDR_W  to RAM address port.
REQ-014 ram_in  output  DATA_W  to RAM write-data port.
REQ-015 ram_load  output  1  to RAM load; RAM writes M[ram_address] <= ram_in on rising edge when 1.
REQ-016 ram_out  input  DATA_W  combinational RAM read data (M[ram_address]).

Function
REQ-017 FSM states SHALL be IDLE, ACCESS, DONE; transitions: IDLE->ACCESS when any req=1, else stay; ACCESS->DONE always; DONE->IDLE always.
REQ-018 In IDLE on a clock edge with any req=1, the winner's we/addr/wdata and identity SHALL be latched; later requester input changes SHALL NOT affect the transaction.
REQ-019 ram_address and ram_in SHALL always drive the latched address/data registers.
REQ-020 ram_load SHALL be 1 only in ACCESS with latched we=1; 0 in all other states.
REQ-021 On the edge leaving ACCESS with latched we=0, ram_out SHALL be captured into the winner's rdata register; the other requester's rdata SHALL be unchanged, and a write SHALL leave both rdata registers unchanged.
REQ-022 The winner's ack SHALL be 1 exactly during DONE; the loser's ack SHALL stay 0.
REQ-023 Latency: req sampled at edge k -> ACCESS in cycle k+1 -> ack in cycle k+2; at most one transaction per 3 cycles.
REQ-024 A req still 1 in the IDLE cycle following DONE SHALL be treated as a new transaction, and requesters SHALL drop req in the ack cycle for single transfers.
REQ-025 Only one requester requesting: that requester SHALL win.
REQ-026 Both requesting: the requester not served last SHALL win (round-robin, see REQ-031).
REQ-027 Both acks SHALL never be 1 in the same cycle.

Reset
REQ-028 When rst_n=0, the block SHALL immediately enter state IDLE; ram_load, a_ack and b_ack SHALL be 0, and ram_address, ram_in, a_rdata and b_rdata SHALL be 0.
REQ-029 Reset SHALL set the last-served pointer to B, so that A wins the first tie.
REQ-030 Reset asserted during ACCESS SHALL drop ram_load asynchronously, so that no write occurs on subsequent edges; the aborted transaction SHALL never be acked.

Configuration
REQ-031 Macro RAM512_ARB_FIXED_PRIO_EN: when defined, A SHALL always win a tie and the last-served pointer SHALL be absent; when undefined, round-robin per REQ-026 and REQ-029 SHALL apply.

Verification
REQ-032 Reset, then hold A: we=1, addr=9'h005, wdata=16'hBEEF for one edge -> ram_load=1 only in ACCESS with ram_address=5 and ram_in=16'hBEEF, a_ack pulses in cycle k+2, b_ack=0.
REQ-033 After REQ-032, A read addr 5 -> a_rdata=16'hBEEF with a_ack, ram_load=0 throughout.
REQ-034 a_req and b_req held high together for 4 transactions, default build -> grant order A,B,A,B; with RAM512_ARB_FIXED_PRIO_EN -> A,A,A,A.
REQ-035 B writes 16'h1234 to addr 9'h1FF, then A reads addr 9'h1FF -> a_rdata=16'h1234, b_rdata unchanged.
REQ-036 Pulse rst_n low during ACCESS of an A write to addr 3 -> ram_load falls immediately, no a_ack, subsequent read of addr 3 returns the prior value.
REQ-037 Change a_addr from 10 to 20 during ACCESS of an A read -> ram_address stays 10 and a_rdata=M[10].

Source files
------------

// File: rtl/ram512_arbiter_if.sv
// ram512_arbiter_if: bundles the two requester ports and the RAM port of
// the shared 512-word RAM arbiter. The slave modport is the arbiter's view;
// the master modport is the view of whatever drives the requesters and
// models the RAM.
`default_nettype none

interface ram512_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic [DATA_W-1:0] b_rdata;

  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_in;
  logic              ram_load;
  logic [DATA_W-1:0] ram_out;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_ack, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_ack, b_rdata,
    output ram_address, ram_in, ram_load,
    input  ram_out
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_ack, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_ack, b_rdata,
    input  ram_address, ram_in, ram_load,
    output ram_out
  );
endinterface

`default_nettype wire

// File: rtl/ram512_arbiter.sv
// ram512_arbiter: two-requester arbiter in front of a single-port 512-word
// RAM. Each transaction takes IDLE -> ACCESS -> DONE; the winner's request
// is latched on the edge leaving IDLE, so later requester input changes do
// not disturb it. Ties are resolved round-robin (A wins the first tie after
// reset). Defining RAM512_ARB_FIXED_PRIO_EN makes A win every tie and
// removes the last-served pointer.
`default_nettype none

module ram512_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  ram512_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic              any_req;
  logic              grant_b;
  logic              lat_we;
  logic              lat_sel_b;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  assign any_req = bus.a_req | bus.b_req;

`ifdef RAM512_ARB_FIXED_PRIO_EN
  // B only wins when it is the sole requester; A takes every tie.
  always_comb begin
    grant_b = bus.b_req & ~bus.a_req;
  end
`else
  logic last_b;

  // On a tie, the requester that was not served most recently wins.
  always_comb begin
    grant_b = bus.b_req;
    if (bus.a_req && bus.b_req) begin
      grant_b = ~last_b;
    end
  end

  // Remember who was granted; reset points at B so A wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_b <= grant_b;
    end
  end
`endif

  // Next-state logic: a request starts a fixed three-cycle transaction.
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = any_req ? ACCESS : IDLE;
      ACCESS:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset forces IDLE at once, which also drops ram_load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the winner's request so it stays stable for the whole transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we    <= 1'b0;
      lat_sel_b <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (state == IDLE && any_req) begin
      lat_sel_b <= grant_b;
      lat_we    <= grant_b ? bus.b_we    : bus.a_we;
      lat_addr  <= grant_b ? bus.b_addr  : bus.a_addr;
      lat_wdata <= grant_b ? bus.b_wdata : bus.a_wdata;
    end
  end

  // Read data lands in the winner's register on the edge leaving ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else if (state == ACCESS && !lat_we) begin
      if (lat_sel_b) begin
        b_rdata_q <= bus.ram_out;
      end else begin
        a_rdata_q <= bus.ram_out;
      end
    end
  end

  assign bus.ram_address = lat_addr;
  assign bus.ram_in      = lat_wdata;
  assign bus.ram_load    = (state == ACCESS) && lat_we;
  assign bus.a_ack       = (state == DONE) && !lat_sel_b;
  assign bus.b_ack       = (state == DONE) && lat_sel_b;
  assign bus.a_rdata     = a_rdata_q;
  assign bus.b_rdata     = b_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_ram512_arbiter.sv
// tb_ram512_arbiter: drives directed and random transactions through the
// arbiter, models the RAM behind it, and compares every observable output
// against a transaction-level reference (expected winner, reference memory
// contents, expected read-data registers).
`default_nettype none

module tb_ram512_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [15:0] mem     [512];
  logic [15:0] ref_mem [512];
  logic [15:0] ref_a_rdata;
  logic [15:0] ref_b_rdata;
  logic        ref_last_was_b;

  ram512_arbiter_if #(.ADDR_W(9), .DATA_W(16)) bus ();

  ram512_arbiter #(.ADDR_W(9), .DATA_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational RAM read port.
  assign bus.ram_out = mem[bus.ram_address];

  // RAM contents: seeded once, then written whenever the arbiter loads.
  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i]     = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    forever begin
      @(posedge clk);
      if (bus.ram_load) mem[bus.ram_address] <= bus.ram_in;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference arbitration: a sole requester wins; on a tie A wins under
  // fixed priority, otherwise whoever was not served last wins.
  function automatic logic refWinnerIsB(input logic ar, input logic br);
    if (ar && !br) return 1'b0;
    if (br && !ar) return 1'b1;
`ifdef RAM512_ARB_FIXED_PRIO_EN
    return 1'b0;
`else
    return !ref_last_was_b;
`endif
  endfunction

  // One complete transaction, entered and left at a falling edge in IDLE.
  task automatic applyStimulus(
    input logic ar, input logic aw, input logic [8:0] aa, input logic [15:0] ad,
    input logic br, input logic bw, input logic [8:0] ba, input logic [15:0] bd,
    input logic [8:0] a_alt_addr
  );
    logic        win_b;
    logic        w_we;
    logic [8:0]  w_addr;
    logic [15:0] w_data;
    bus.a_req = ar; bus.a_we = aw; bus.a_addr = aa; bus.a_wdata = ad;
    bus.b_req = br; bus.b_we = bw; bus.b_addr = ba; bus.b_wdata = bd;
    if (!ar && !br) begin
      @(negedge clk);
      checkOutput("idle_ram_load", 32'(bus.ram_load), 32'd0);
      checkOutput("idle_a_ack", 32'(bus.a_ack), 32'd0);
      checkOutput("idle_b_ack", 32'(bus.b_ack), 32'd0);
      return;
    end
    win_b  = refWinnerIsB(ar, br);
    w_we   = win_b ? bw : aw;
    w_addr = win_b ? ba : aa;
    w_data = win_b ? bd : ad;

    @(negedge clk);
    checkOutput("access_ram_load", 32'(bus.ram_load), 32'(w_we));
    checkOutput("access_ram_address", 32'(bus.ram_address), 32'(w_addr));
    checkOutput("access_ram_in", 32'(bus.ram_in), 32'(w_data));
    checkOutput("access_a_ack", 32'(bus.a_ack), 32'd0);
    checkOutput("access_b_ack", 32'(bus.b_ack), 32'd0);
    bus.a_addr  = a_alt_addr;
    bus.a_we    = ~aw;
    bus.a_wdata = 16'($urandom);
    bus.b_addr  = 9'($urandom);
    bus.b_we    = ~bw;
    bus.b_wdata = 16'($urandom);

    @(negedge clk);
    if (w_we) ref_mem[w_addr] = w_data;
    else if (win_b) ref_b_rdata = ref_mem[w_addr];
    else ref_a_rdata = ref_mem[w_addr];
    ref_last_was_b = win_b;
    checkOutput("done_a_ack", 32'(bus.a_ack), 32'(!win_b));
    checkOutput("done_b_ack", 32'(bus.b_ack), 32'(win_b));
    checkOutput("done_ram_load", 32'(bus.ram_load), 32'd0);
    checkOutput("done_a_rdata", 32'(bus.a_rdata), 32'(ref_a_rdata));
    checkOutput("done_b_rdata", 32'(bus.b_rdata), 32'(ref_b_rdata));
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;

    @(negedge clk);
    checkOutput("after_a_ack", 32'(bus.a_ack), 32'd0);
    checkOutput("after_b_ack", 32'(bus.b_ack), 32'd0);
    checkOutput("after_ram_load", 32'(bus.ram_load), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    ref_a_rdata    = 16'h0;
    ref_b_rdata    = 16'h0;
    ref_last_was_b = 1'b1;
    rst_n = 1'b0;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;

    // Reset values.
    @(negedge clk);
    checkOutput("rst_ram_load", 32'(bus.ram_load), 32'd0);
    checkOutput("rst_a_ack", 32'(bus.a_ack), 32'd0);
    checkOutput("rst_b_ack", 32'(bus.b_ack), 32'd0);
    checkOutput("rst_ram_address", 32'(bus.ram_address), 32'd0);
    checkOutput("rst_ram_in", 32'(bus.ram_in), 32'd0);
    checkOutput("rst_a_rdata", 32'(bus.a_rdata), 32'd0);
    checkOutput("rst_b_rdata", 32'(bus.b_rdata), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // A writes BEEF to 5, then reads it back.
    applyStimulus(1'b1, 1'b1, 9'h005, 16'hBEEF, 1'b0, 1'b0, 9'h000, 16'h0, 9'h005);
    applyStimulus(1'b1, 1'b0, 9'h005, 16'h0000, 1'b0, 1'b0, 9'h000, 16'h0, 9'h005);
    checkOutput("beef_readback", 32'(bus.a_rdata), 32'h0000BEEF);

    // B writes 1234 to the top word, A reads it.
    applyStimulus(1'b0, 1'b0, 9'h000, 16'h0, 1'b1, 1'b1, 9'h1FF, 16'h1234, 9'h000);
    applyStimulus(1'b1, 1'b0, 9'h1FF, 16'h0, 1'b0, 1'b0, 9'h000, 16'h0, 9'h000);
    checkOutput("top_word_readback", 32'(bus.a_rdata), 32'h00001234);

    // Four ties in a row exercise the tie-break order.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 9'(i), 16'h0, 1'b1, 1'b0, 9'(i + 100), 16'h0, 9'h000);
    end

    // A read of 10 whose address moves to 20 mid-transaction.
    applyStimulus(1'b1, 1'b0, 9'd10, 16'h0, 1'b0, 1'b0, 9'h000, 16'h0, 9'd20);
    checkOutput("addr_change_rdata", 32'(bus.a_rdata), 32'(ref_mem[10]));

    // Seed address 3, then abort a second write to it with reset during ACCESS.
    applyStimulus(1'b1, 1'b1, 9'd3, 16'h0A0A, 1'b0, 1'b0, 9'h000, 16'h0, 9'd3);
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 9'd3; bus.a_wdata = 16'hDEAD;
    @(negedge clk);
    checkOutput("abort_load_before", 32'(bus.ram_load), 32'd1);
    #2 rst_n = 1'b0;
    #1 checkOutput("abort_load_async", 32'(bus.ram_load), 32'd0);
    @(negedge clk);
    checkOutput("abort_a_ack", 32'(bus.a_ack), 32'd0);
    checkOutput("abort_ram_load", 32'(bus.ram_load), 32'd0);
    bus.a_req = 1'b0;
    rst_n = 1'b1;
    ref_a_rdata    = 16'h0;
    ref_b_rdata    = 16'h0;
    ref_last_was_b = 1'b1;
    @(negedge clk);
    checkOutput("abort_no_late_ack", 32'(bus.a_ack), 32'd0);
    applyStimulus(1'b1, 1'b0, 9'd3, 16'h0, 1'b0, 1'b0, 9'h000, 16'h0, 9'd3);
    checkOutput("abort_prior_value", 32'(bus.a_rdata), 32'h00000A0A);

    // Random traffic.
    for (int n = 0; n < 60; n++) begin
      logic [1:0] pat;
      pat = 2'($urandom_range(0, 3));
      applyStimulus(pat[0], 1'($urandom), 9'($urandom), 16'($urandom),
                    pat[1], 1'($urandom), 9'($urandom), 16'($urandom),
                    9'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
